tohost_monitor: RTL and testbench

Synthesizable end-of-test detector inside the test harness: snoops a write bus for stores to the `tohost` address, decodes exit requests, and drives the harness completion status (`io_success` / `io_failure`) that the simulation driver polls each clock. It holds status sticky after a configurable drain delay. Optionally it forwards console characters from the same `tohost` channel to a character output stream.

---
 rtl/tohost_pkg.sv | 18 +
 rtl/tohost_char_buffer.sv | 33 +++
 rtl/tohost_monitor.sv | 112 +++++++++++
 tb/tb_tohost_monitor.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tohost_pkg.sv
// Shared types and field positions for the tohost end-of-test monitor.
package tohost_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] TOHOST_DEV_CONSOLE = 8'd1;
  localparam logic [7:0] TOHOST_CMD_PUTCHAR = 8'd1;

  // tohost word layout: device in [63:56], command in [55:48], payload below
  localparam int TOHOST_DEV_LSB = 56;
  localparam int TOHOST_CMD_LSB = 48;
  localparam int TOHOST_EXIT_BIT = 0;

endpackage

// File: rtl/tohost_char_buffer.sv
// One-entry valid/ready register for console characters; output is registered (1 cycle),
// accepts a new character in the same cycle the held one drains, stalls input while full and not draining.
module tohost_char_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data
);

  logic       r_vld;
  logic [7:0] r_dat;

  assign o_in_ready  = !r_vld || i_out_ready;
  assign o_out_valid = r_vld;
  assign o_out_data  = r_dat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_dat <= 8'd0;
    end else if (i_in_valid && o_in_ready) begin
      r_vld <= 1'b1;
      r_dat <= i_in_data;
    end else if (i_out_ready) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops tohost stores, latches the first exit code and raises sticky pass/fail after DRAIN_CYCLES+1 cycles.
// Console forwarding of putchar writes is built only when TOHOST_CONSOLE_EN is defined.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = 32'h8000_1000,
  parameter int                    DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  io_success,
  output logic                  io_failure,
  output logic [DATA_WIDTH-2:0] exit_code,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_drain_cnt;
  logic [7:0]            w_drain_cnt_nxt;
  logic [DATA_WIDTH-2:0] r_exit_code;
  logic [DATA_WIDTH-2:0] w_exit_code_nxt;
  logic                  w_tohost_fire;
  logic                  w_exit_req;

  assign w_tohost_fire = wr_valid && wr_ready && (wr_addr == TOHOST_ADDR);

`ifdef TOHOST_CONSOLE_EN
  logic [7:0] w_dev;
  logic [7:0] w_cmd;
  logic       w_putc;

  assign w_dev      = wr_data[TOHOST_DEV_LSB +: 8];
  assign w_cmd      = wr_data[TOHOST_CMD_LSB +: 8];
  assign w_exit_req = w_tohost_fire && wr_data[TOHOST_EXIT_BIT] && (w_dev == 8'd0);
  assign w_putc     = w_tohost_fire && (w_dev == TOHOST_DEV_CONSOLE) && (w_cmd == TOHOST_CMD_PUTCHAR);

  // Buffer input-ready never looks at valid, so wr_ready -> w_putc is not a loop.
  tohost_char_buffer u_char_buffer (
    .clk        (clk),
    .reset      (reset),
    .i_in_valid (w_putc),
    .o_in_ready (wr_ready),
    .i_in_data  (wr_data[7:0]),
    .o_out_valid(char_valid),
    .i_out_ready(char_ready),
    .o_out_data (char_data)
  );
`else
  logic w_unused_char_ready;

  assign w_exit_req          = w_tohost_fire && wr_data[TOHOST_EXIT_BIT];
  assign wr_ready            = 1'b1;
  assign char_valid          = 1'b0;
  assign char_data           = 8'd0;
  assign w_unused_char_ready = char_ready;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_drain_cnt <= 8'd0;
      r_exit_code <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_exit_code <= w_exit_code_nxt;
    end
  end

  // A zero drain delay still spends one cycle in DRAIN, so status always lands at fire+1+DRAIN_CYCLES.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_exit_code_nxt = r_exit_code;
    case (r_state)
      RUN: begin
        if (w_exit_req) begin
          w_state_nxt     = DRAIN;
          w_drain_cnt_nxt = 8'(DRAIN_CYCLES);
          w_exit_code_nxt = wr_data[DATA_WIDTH-1:1];
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 8'd0) begin
          w_state_nxt = DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 8'd1;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign io_success = (r_state == DONE) && (r_exit_code == '0);
  assign io_failure = (r_state == DONE) && (r_exit_code != '0);
  assign exit_code  = r_exit_code;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: two instances (drain 4 and drain 0) share one write bus and
// are compared each cycle against a cycle-count reference model of the exit/console rules.
module tb_tohost_monitor;

  localparam logic [31:0] TA = 32'h8000_1000;
  localparam int D0 = 4;
  localparam int D1 = 0;
`ifdef TOHOST_CONSOLE_EN
  localparam bit CONSOLE = 1'b1;
`else
  localparam bit CONSOLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        char_ready = 1'b0;

  logic        rdy0, succ0, fail0, cv0;
  logic [62:0] code0;
  logic [7:0]  cd0;
  logic        rdy1, succ1, fail1, cv1;
  logic [62:0] code1;
  logic [7:0]  cd1;

  tohost_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TOHOST_ADDR(TA), .DRAIN_CYCLES(D0)) u_d4 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy0), .wr_addr(wr_addr),
    .wr_data(wr_data), .io_success(succ0), .io_failure(fail0), .exit_code(code0),
    .char_valid(cv0), .char_ready(char_ready), .char_data(cd0));

  tohost_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TOHOST_ADDR(TA), .DRAIN_CYCLES(D1)) u_d0 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy1), .wr_addr(wr_addr),
    .wr_data(wr_data), .io_success(succ1), .io_failure(fail1), .exit_code(code1),
    .char_valid(cv1), .char_ready(char_ready), .char_data(cd1));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: when the first exit happened and what the console slot holds.
  bit          m_exited;
  int          m_fire;
  logic [62:0] m_code;
  bit          m_cv;
  logic [7:0]  m_cd;

  function automatic bit m_ready();
    return !(CONSOLE && m_cv && !char_ready);
  endfunction

  function automatic bit m_succ(input int d);
    return m_exited && (cyc >= m_fire + 1 + d) && (m_code == '0);
  endfunction

  function automatic bit m_fail(input int d);
    return m_exited && (cyc >= m_fire + 1 + d) && (m_code != '0);
  endfunction

  function automatic logic [62:0] m_exit_code();
    return m_exited ? m_code : '0;
  endfunction

  task automatic model_clear();
    m_exited = 1'b0;
    m_fire   = 0;
    m_code   = '0;
    m_cv     = 1'b0;
    m_cd     = '0;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [63:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  // One rising edge; the model applies the rules to the inputs seen before the edge.
  task automatic tick();
    bit fire, hit;
    logic [7:0] dev, cmd;
    fire = wr_valid && m_ready();
    hit  = fire && (wr_addr == TA);
    dev  = wr_data[63:56];
    cmd  = wr_data[55:48];
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_clear();
    end else begin
      if (hit && wr_data[0] && (!CONSOLE || dev == 8'd0) && !m_exited) begin
        m_exited = 1'b1;
        m_fire   = cyc;
        m_code   = wr_data[63:1];
      end
      if (m_cv && char_ready) m_cv = 1'b0;
      if (CONSOLE && hit && dev == 8'd1 && cmd == 8'd1) begin
        m_cv = 1'b1;
        m_cd = wr_data[7:0];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0);
    char_ready = 1'b0;
    reset = 1'b0;
    model_clear();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if ({succ0, fail0, succ1, fail1, cv0, cv1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_status got=%b want=000000", {succ0, fail0, succ1, fail1, cv0, cv1});
    end
    tick();
    tick();
    vectors++;
    if (code0 !== 63'd0 || code1 !== 63'd0 || cd0 !== 8'd0 || cd1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs code=%h/%h cd=%h/%h want zeros", code0, code1, cd0, cd1);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({rdy0, rdy1, succ0, fail0, succ1, fail1} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_release got=%b want=110000", {rdy0, rdy1, succ0, fail0, succ1, fail1});
    end
  endtask

  task automatic test_pass();
    int fire, rise0, rise1;
    do_reset();
    drive(1'b1, TA, 64'h1);
    tick();
    fire = cyc;
    drive(1'b0, '0, '0);
    rise0 = -1;
    rise1 = -1;
    for (int i = 0; i < 110; i++) begin
      vectors++;
      if ({succ0, fail0, succ1, fail1} !== {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)}) begin
        errors++;
        $display("FAIL pass_status cyc=%0d got=%b want=%b", cyc, {succ0, fail0, succ1, fail1},
                 {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)});
      end
      vectors++;
      if (code0 !== m_exit_code() || code1 !== m_exit_code()) begin
        errors++;
        $display("FAIL pass_code cyc=%0d got=%h/%h want=%h", cyc, code0, code1, m_exit_code());
      end
      if (succ0 && rise0 < 0) rise0 = cyc - fire;
      if (succ1 && rise1 < 0) rise1 = cyc - fire;
      tick();
    end
    vectors++;
    if (rise0 !== 5 || rise1 !== 1) begin
      errors++;
      $display("FAIL pass_latency got=%0d/%0d want=5/1", rise0, rise1);
    end
  endtask

  task automatic test_fail_first_wins();
    bit seen;
    do_reset();
    drive(1'b1, TA, 64'h7);
    tick();
    drive(1'b0, '0, '0);
    tick();
    drive(1'b1, TA, 64'h1);
    tick();
    drive(1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({succ0, fail0, succ1, fail1} !== {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)} ||
          code0 !== m_exit_code() || code1 !== m_exit_code()) begin
        errors++;
        $display("FAIL firstwin_cycle cyc=%0d got=%b code=%h want=%b code=%h", cyc,
                 {succ0, fail0, succ1, fail1}, code0,
                 {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)}, m_exit_code());
      end
      seen = seen | succ0 | succ1;
      tick();
    end
    vectors++;
    if (!(fail0 === 1'b1 && fail1 === 1'b1 && code0 === 63'd3 && code1 === 63'd3 && seen === 1'b0)) begin
      errors++;
      $display("FAIL firstwin_final fail=%b%b code=%h/%h success_seen=%b want fail=11 code=3 seen=0",
               fail0, fail1, code0, code1, seen);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] a;
    logic [63:0] d;
    do_reset();
    drive(1'b1, TA + 32'd8, 64'h1);
    tick();
    drive(1'b1, TA, 64'h0);
    tick();
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 1) ? TA : TA + 32'(4 * $urandom_range(1, 64));
      d = {$urandom, $urandom};
      if (a == TA) begin
        d[0] = 1'b0;
        if (d[63:56] == 8'd1) d[63:56] = 8'd2;
      end
      vectors++;
      if ({succ0, fail0, succ1, fail1, rdy0, rdy1} !== 6'b000011 || code0 !== 63'd0) begin
        errors++;
        $display("FAIL ignored cyc=%0d got=%b code=%h want=000011 code=0", cyc,
                 {succ0, fail0, succ1, fail1, rdy0, rdy1}, code0);
      end
      drive(1'b1, a, d);
      tick();
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_drain();
    int fire, rise0, rise1;
    do_reset();
    drive(1'b1, TA, 64'h1);
    tick();
    drive(1'b0, '0, '0);
    tick();
    tick();
    vectors++;
    if ({succ0, succ1} !== 2'b01) begin
      errors++;
      $display("FAIL middrain_pre got=%b want=01", {succ0, succ1});
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({succ0, fail0, succ1, fail1, cv0, cv1} !== 6'b0 || code0 !== 63'd0 || code1 !== 63'd0) begin
      errors++;
      $display("FAIL middrain_async got=%b code=%h/%h want zeros", {succ0, fail0, succ1, fail1, cv0, cv1},
               code0, code1);
    end
    model_clear();
    tick();
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, TA, 64'h1);
    tick();
    fire = cyc;
    drive(1'b0, '0, '0);
    rise0 = -1;
    rise1 = -1;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({succ0, fail0, succ1, fail1} !== {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)}) begin
        errors++;
        $display("FAIL middrain_rerun cyc=%0d got=%b want=%b", cyc, {succ0, fail0, succ1, fail1},
                 {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)});
      end
      if (succ0 && rise0 < 0) rise0 = cyc - fire;
      if (succ1 && rise1 < 0) rise1 = cyc - fire;
      tick();
    end
    vectors++;
    if (rise0 !== 5 || rise1 !== 1) begin
      errors++;
      $display("FAIL middrain_latency got=%0d/%0d want=5/1", rise0, rise1);
    end
  endtask

  task automatic test_console();
    do_reset();
    char_ready = 1'b0;
    drive(1'b1, TA, 64'h0101_0000_0000_0041);
    tick();
`ifdef TOHOST_CONSOLE_EN
    drive(1'b1, TA, 64'h0101_0000_0000_0042);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({cv0, cv1, rdy0, rdy1} !== 4'b1100 || cd0 !== 8'h41 || cd1 !== 8'h41) begin
        errors++;
        $display("FAIL console_hold got=%b cd=%h/%h want=1100 cd=41", {cv0, cv1, rdy0, rdy1}, cd0, cd1);
      end
      tick();
    end
    char_ready = 1'b1;
    #1;
    vectors++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errors++;
      $display("FAIL console_ready_comb got=%b want=11", {rdy0, rdy1});
    end
    tick();
    vectors++;
    if ({cv0, cv1} !== 2'b11 || cd0 !== 8'h42 || cd1 !== 8'h42) begin
      errors++;
      $display("FAIL console_refill got=%b cd=%h want=11 cd=42", {cv0, cv1}, cd0);
    end
    drive(1'b1, TA, 64'h0101_0000_0000_0043);
    tick();
    drive(1'b0, '0, '0);
    vectors++;
    if ({cv0, rdy0} !== 2'b11 || cd0 !== 8'h43 || {succ0, fail0, succ1, fail1} !== 4'b0) begin
      errors++;
      $display("FAIL console_nobubble got=%b cd=%h status=%b want=11 cd=43 status=0000", {cv0, rdy0}, cd0,
               {succ0, fail0, succ1, fail1});
    end
    tick();
    vectors++;
    if ({cv0, cv1} !== {m_cv, m_cv} || m_cv !== 1'b0) begin
      errors++;
      $display("FAIL console_drain got=%b want=00", {cv0, cv1});
    end
`else
    drive(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({cv0, cv1, rdy0, rdy1} !== 4'b0011 || cd0 !== 8'd0 || cd1 !== 8'd0) begin
        errors++;
        $display("FAIL console_off cyc=%0d got=%b cd=%h want=0011 cd=0", cyc, {cv0, cv1, rdy0, rdy1}, cd0);
      end
      tick();
    end
    vectors++;
    if (fail0 !== 1'b1 || succ0 !== 1'b0 || code0 !== 63'h0080_8000_0000_0020) begin
      errors++;
      $display("FAIL console_off_exit fail=%b succ=%b code=%h want fail=1 code=0080800000000020",
               fail0, succ0, code0);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [63:0] d;
    logic [63:0] r64;
    bit v;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        v   = ($urandom_range(0, 9) < 6);
        a   = ($urandom_range(0, 3) != 0) ? TA : $urandom;
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 9))
          0:       d = 64'h1;
          1, 2:    begin d = r64 | 64'h1; d[63:56] = 8'd0; end
          3, 4, 5: begin d = r64; d[63:48] = 16'h0101; end
          default: d = r64 & ~64'h1;
        endcase
        drive(v, a, d);
        char_ready = ($urandom_range(0, 2) != 0);
        #1;
        vectors++;
        if ({rdy0, rdy1} !== {m_ready(), m_ready()}) begin
          errors++;
          $display("FAIL random_ready cyc=%0d got=%b want=%b", cyc, {rdy0, rdy1}, {m_ready(), m_ready()});
        end
        tick();
        vectors++;
        if ({succ0, fail0, succ1, fail1} !== {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)} ||
            code0 !== m_exit_code() || code1 !== m_exit_code()) begin
          errors++;
          $display("FAIL random_status cyc=%0d got=%b code=%h/%h want=%b code=%h", cyc,
                   {succ0, fail0, succ1, fail1}, code0, code1,
                   {m_succ(D0), m_fail(D0), m_succ(D1), m_fail(D1)}, m_exit_code());
        end
        vectors++;
        if ({cv0, cv1} !== {m_cv, m_cv} || (m_cv && (cd0 !== m_cd || cd1 !== m_cd))) begin
          errors++;
          $display("FAIL random_char cyc=%0d got=%b cd=%h/%h want=%b cd=%h", cyc, {cv0, cv1}, cd0, cd1,
                   {m_cv, m_cv}, m_cd);
        end
      end
    end
    drive(1'b0, '0, '0);
  endtask

  initial begin
    model_clear();
    #2;
    test_reset();
    test_pass();
    test_fail_first_wins();
    test_ignored();
    test_reset_mid_drain();
    test_console();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
